// File: rtl/maxnet_pkg.sv
// Shared definitions for the MaxNet winner-take-all stage:
// FSM state encoding, a constant-evaluable clog2 and adder-tree width helpers.
package maxnet_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_e;

    // Ceiling log2, usable in parameter and port-width expressions.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) r = r + 1;
        return r;
    endfunction

    // Width needed to sum n unsigned w-bit values without overflow.
    function automatic int unsigned sum_width(input int unsigned n, input int unsigned w);
        return w + clog2(n);
    endfunction

    localparam int unsigned SUM_W_DEFAULT = sum_width(4, 8);

endpackage

// File: rtl/maxnet_neuron.sv
// One MaxNet neuron: combinational lateral-inhibition update.
// a' = a - ((S - a) >> EPS_SHIFT), clamped at zero.
module maxnet_neuron
    import maxnet_pkg::*;
#(
    parameter int unsigned W         = 8,
    parameter int unsigned SUM_W     = SUM_W_DEFAULT,
    parameter int unsigned EPS_SHIFT = 3
) (
    input  logic [W-1:0]     a_i,
    input  logic [SUM_W-1:0] sum_i,
    output logic [W-1:0]     a_o
);

    logic [SUM_W-1:0] others;
    logic [SUM_W-1:0] inhib;

    // Inhibition from all other neurons, then clamp so the result never wraps.
    always_comb begin
        others = sum_i - SUM_W'(a_i);
        inhib  = others >> EPS_SHIFT;
        // inhib < a_i on the subtract path, so its low W bits are exact
        a_o    = (SUM_W'(a_i) > inhib) ? (a_i - inhib[W-1:0]) : '0;
    end

endmodule

// File: rtl/maxnet_iter_ctrl.sv
// Iterative MaxNet winner-take-all controller.
// Loads N activations on start, applies one parallel inhibition update per
// clock until at most one neuron stays nonzero (or the update stalls), then
// reports the lowest-indexed nonzero neuron and its residual activation.
// Optional build macro MAXNET_TIMEOUT_EN adds an iteration limit of MAX_ITER.
module maxnet_iter_ctrl
    import maxnet_pkg::*;
#(
    parameter int unsigned N         = 4,
    parameter int unsigned W         = 8,
    parameter int unsigned EPS_SHIFT = 3,
    parameter int unsigned ITER_W    = 8,
    parameter int unsigned MAX_ITER  = 64
) (
    input  logic                  CLK,
    input  logic                  CLR,
    input  logic                  start,
    input  logic [N*W-1:0]        act_in,
    output logic                  busy,
    output logic                  done,
    output logic                  win_valid,
    output logic                  no_winner,
    output logic                  timeout,
    output logic [clog2(N)-1:0]   winner,
    output logic [W-1:0]          win_act,
    output logic [ITER_W-1:0]     iter_count,
    output logic [N*W-1:0]        act_out
);

    localparam int unsigned IDX_W = clog2(N);
    localparam int unsigned SUM_W = sum_width(N, W);
    localparam int unsigned CNT_W = clog2(N + 1);
    localparam logic [ITER_W-1:0] ITER_LIMIT = ITER_W'(MAX_ITER);

    state_e             state_q, state_d;
    logic [N*W-1:0]     act_q, act_d;
    logic [ITER_W-1:0]  iter_q, iter_d;
    logic               win_valid_q, win_valid_d;
    logic               no_winner_q, no_winner_d;
    logic               timeout_q, timeout_d;
    logic [IDX_W-1:0]   winner_q, winner_d;
    logic [W-1:0]       win_act_q, win_act_d;

    logic [SUM_W-1:0]   sum;
    logic [N*W-1:0]     act_nxt;
    logic [CNT_W-1:0]   nz_cnt;
    logic [IDX_W-1:0]   enc_idx;
    logic [W-1:0]       enc_act;
    logic               enc_found;
    logic [ITER_W-1:0]  iter_inc;
    logic               stall;
    logic               fin_nz;
    logic               timeout_hit;

    // Total activation feeding every neuron's inhibition term.
    always_comb begin
        sum = '0;
        for (int i = 0; i < N; i++) begin
            sum = sum + SUM_W'(act_q[i*W +: W]);
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_neuron
        maxnet_neuron #(
            .W         (W),
            .SUM_W     (SUM_W),
            .EPS_SHIFT (EPS_SHIFT)
        ) u_neuron (
            .a_i   (act_q[g*W +: W]),
            .sum_i (sum),
            .a_o   (act_nxt[g*W +: W])
        );
    end

    // Nonzero count and lowest-index priority encoder over the updated values.
    always_comb begin
        nz_cnt    = '0;
        enc_idx   = '0;
        enc_act   = '0;
        enc_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (act_nxt[i*W +: W] != '0) begin
                nz_cnt = nz_cnt + CNT_W'(1);
                if (!enc_found) begin
                    enc_found = 1'b1;
                    enc_idx   = IDX_W'(i);
                    enc_act   = act_nxt[i*W +: W];
                end
            end
        end
    end

    assign iter_inc = (iter_q == '1) ? iter_q : iter_q + ITER_W'(1);
    assign stall    = (act_nxt == act_q);
    assign fin_nz   = (nz_cnt <= CNT_W'(1));

`ifdef MAXNET_TIMEOUT_EN
    assign timeout_hit = (iter_inc >= ITER_LIMIT);
`else
    logic unused_iter_limit;
    assign unused_iter_limit = ^ITER_LIMIT;
    assign timeout_hit       = 1'b0;
`endif

    // Next-state and next-register logic for the load/iterate/report sequence.
    always_comb begin
        // NOTE: every signal gets its hold value first so no path infers a latch.
        state_d     = state_q;
        act_d       = act_q;
        iter_d      = iter_q;
        win_valid_d = win_valid_q;
        no_winner_d = no_winner_q;
        timeout_d   = timeout_q;
        winner_d    = winner_q;
        win_act_d   = win_act_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = ITER;
                    act_d       = act_in;
                    iter_d      = '0;
                    win_valid_d = 1'b0;
                    no_winner_d = 1'b0;
                    timeout_d   = 1'b0;
                    winner_d    = '0;
                    win_act_d   = '0;
                end
            end
            ITER: begin
                act_d  = act_nxt;
                iter_d = iter_inc;
                if (fin_nz || stall || timeout_hit) begin
                    state_d     = DONE;
                    win_valid_d = (nz_cnt == CNT_W'(1));
                    no_winner_d = (nz_cnt != CNT_W'(1));
                    timeout_d   = !fin_nz && !stall;
                    winner_d    = enc_idx;
                    win_act_d   = enc_act;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            // NOTE: the activations are N flops rather than a memory, so they clear with everything else.
            state_q     <= IDLE;
            act_q       <= '0;
            iter_q      <= '0;
            win_valid_q <= 1'b0;
            no_winner_q <= 1'b0;
            timeout_q   <= 1'b0;
            winner_q    <= '0;
            win_act_q   <= '0;
        end else begin
            // NOTE: non-blocking so every register samples values from before the edge.
            state_q     <= state_d;
            act_q       <= act_d;
            iter_q      <= iter_d;
            win_valid_q <= win_valid_d;
            no_winner_q <= no_winner_d;
            timeout_q   <= timeout_d;
            winner_q    <= winner_d;
            win_act_q   <= win_act_d;
        end
    end

    assign busy       = (state_q == ITER);
    assign done       = (state_q == DONE);
    assign win_valid  = win_valid_q;
    assign no_winner  = no_winner_q;
    assign timeout    = timeout_q;
    assign winner     = winner_q;
    assign win_act    = win_act_q;
    assign iter_count = iter_q;
    assign act_out    = act_q;

endmodule

// File: tb/tb_maxnet_iter_ctrl.sv
// Self-checking bench for maxnet_iter_ctrl (N=4, W=8, EPS_SHIFT=3).
// An integer-arithmetic model tracks the expected outputs every cycle;
// literal expectations from hand-worked examples pin the model.
module tb_maxnet_iter_ctrl;

    localparam int N         = 4;
    localparam int W         = 8;
    localparam int EPS_SHIFT = 3;
    localparam int ITER_W    = 8;
    localparam int MAX_ITER  = 64;

    logic             CLK;
    logic             CLR;
    logic             start;
    logic [N*W-1:0]   act_in;
    logic             busy, done, win_valid, no_winner, timeout;
    logic [1:0]       winner;
    logic [W-1:0]     win_act;
    logic [ITER_W-1:0] iter_count;
    logic [N*W-1:0]   act_out;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 0;

    // Model: 0 = waiting, 1 = iterating, 2 = result held
    int m_phase;
    int m_act[N];
    int m_iter;
    int m_valid, m_nowin, m_to, m_winner, m_winact;

    maxnet_iter_ctrl #(
        .N(N), .W(W), .EPS_SHIFT(EPS_SHIFT), .ITER_W(ITER_W), .MAX_ITER(MAX_ITER)
    ) dut (
        .CLK(CLK), .CLR(CLR), .start(start), .act_in(act_in),
        .busy(busy), .done(done), .win_valid(win_valid), .no_winner(no_winner),
        .timeout(timeout), .winner(winner), .win_act(win_act),
        .iter_count(iter_count), .act_out(act_out)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [N*W-1:0] pack4(input int a3, input int a2, input int a1, input int a0);
        return {8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    endfunction

    function automatic logic [N*W-1:0] model_vec();
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = 8'(m_act[i]);
        return v;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_iter = 0;
        m_valid = 0; m_nowin = 0; m_to = 0; m_winner = 0; m_winact = 0;
        for (int i = 0; i < N; i++) m_act[i] = 0;
    endtask

    task automatic model_step();
        int s, nz, lo, d;
        int nxt[N];
        bit same, to_hit;
        if (m_phase != 1) begin
            if (start) begin
                m_phase = 1; m_iter = 0;
                m_valid = 0; m_nowin = 0; m_to = 0; m_winner = 0; m_winact = 0;
                for (int i = 0; i < N; i++) m_act[i] = int'(act_in[i*W +: W]);
            end
        end else begin
            s = 0;
            for (int i = 0; i < N; i++) s += m_act[i];
            nz = 0; lo = -1; same = 1;
            for (int i = 0; i < N; i++) begin
                d = (s - m_act[i]) / (1 << EPS_SHIFT);
                nxt[i] = (m_act[i] > d) ? m_act[i] - d : 0;
                if (nxt[i] != m_act[i]) same = 0;
                if (nxt[i] != 0) begin
                    nz++;
                    if (lo < 0) lo = i;
                end
            end
            m_iter = (m_iter + 1 > 255) ? 255 : m_iter + 1;
            for (int i = 0; i < N; i++) m_act[i] = nxt[i];
`ifdef MAXNET_TIMEOUT_EN
            to_hit = (m_iter >= MAX_ITER);
`else
            to_hit = 0;
`endif
            if (nz <= 1 || same || to_hit) begin
                m_phase  = 2;
                m_valid  = (nz == 1);
                m_nowin  = (nz != 1);
                m_to     = (nz > 1 && !same) ? 1 : 0;
                m_winner = (lo < 0) ? 0 : lo;
                m_winact = (lo < 0) ? 0 : nxt[lo];
            end
        end
    endtask

    // Model advances on the same edge as the DUT, using the same inputs.
    always @(posedge CLK) begin
        if (CLR) model_reset();
        else     model_step();
    end

    always @(posedge CLR) model_reset();

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge CLK) begin
        if (cmp_en) begin
            check("busy",       busy,       (m_phase == 1));
            check("done",       done,       (m_phase == 2));
            check("win_valid",  win_valid,  m_valid[0]);
            check("no_winner",  no_winner,  m_nowin[0]);
            check("timeout",    timeout,    m_to[0]);
            check("winner",     winner,     m_winner[1:0]);
            check("win_act",    win_act,    m_winact[7:0]);
            check("iter_count", iter_count, m_iter[7:0]);
            check("act_out",    act_out,    model_vec());
        end
    end

    task automatic do_start(input logic [N*W-1:0] v);
        @(negedge CLK);
        act_in = v;
        start  = 1'b1;
        @(negedge CLK);
        start  = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (done !== 1'b1 && k < budget) begin
            @(negedge CLK);
            k++;
        end
        check("wait_done", done, 1'b1);
    endtask

    task automatic clr_pulse_mid_cycle();
        #2 CLR = 1'b1;
        #1;
        check("clr_busy",    busy,       1'b0);
        check("clr_done",    done,       1'b0);
        check("clr_act",     act_out,    '0);
        check("clr_iter",    iter_count, '0);
        check("clr_winact",  win_act,    '0);
        @(negedge CLK);
        CLR = 1'b0;
    endtask

    initial begin
        logic [N*W-1:0] v, v2;
        model_reset();
        CLR = 1'b1; start = 1'b0; act_in = '0;
        cmp_en = 1;
        repeat (2) @(negedge CLK);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_act",  act_out, '0);
        CLR = 1'b0;

        // Two updates to a single survivor
        do_start(pack4(200, 30, 20, 10));
        @(negedge CLK);
        check("t2_act_after1", act_out, pack4(193, 2, 0, 0));
        check("t2_iter_after1", iter_count, 8'd1);
        wait_done(20);
        check("t2_act", act_out, pack4(193, 0, 0, 0));
        check("t2_valid", win_valid, 1'b1);
        check("t2_winner", winner, 2'd3);
        check("t2_winact", win_act, 8'd193);
        check("t2_iter", iter_count, 8'd2);

        // Already a single nonzero neuron: still one update
        do_start(pack4(0, 50, 0, 0));
        wait_done(20);
        check("t3_winner", winner, 2'd2);
        check("t3_winact", win_act, 8'd50);
        check("t3_iter", iter_count, 8'd1);

        // All zero
        do_start(pack4(0, 0, 0, 0));
        wait_done(20);
        check("t4_nowin", no_winner, 1'b1);
        check("t4_valid", win_valid, 1'b0);
        check("t4_winner", winner, 2'd0);
        check("t4_iter", iter_count, 8'd1);

        // Tie converges to a stall at {0,0,7,7}
        do_start(pack4(0, 0, 100, 100));
        wait_done(100);
        check("t5_act", act_out, pack4(0, 0, 7, 7));
        check("t5_nowin", no_winner, 1'b1);
        check("t5_valid", win_valid, 1'b0);
        check("t5_iter", iter_count, 8'd25);

        // start while iterating is ignored
        do_start(pack4(0, 0, 100, 100));
        repeat (3) @(negedge CLK);
        act_in = pack4(9, 9, 9, 9);
        start  = 1'b1;
        @(negedge CLK);
        start  = 1'b0;
        wait_done(100);
        check("t6_act", act_out, pack4(0, 0, 7, 7));
        check("t6_iter", iter_count, 8'd25);
        // start from DONE restarts and clears the flags
        do_start(pack4(0, 50, 0, 0));
        check("t6_restart_done", done, 1'b0);
        check("t6_restart_nowin", no_winner, 1'b0);
        check("t6_restart_act", act_out, pack4(0, 50, 0, 0));
        wait_done(20);
        check("t6_winner", winner, 2'd2);

        // Clear in the middle of a run
        do_start(pack4(100, 100, 100, 100));
        repeat (3) @(negedge CLK);
        clr_pulse_mid_cycle();

        // Randomized runs with stray starts and occasional clears
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < N; i++) begin
                v[i*W +: W] = ($urandom_range(0, 3) == 0) ? 8'(0) : 8'($urandom_range(0, 255));
                v2[i*W +: W] = 8'($urandom_range(0, 255));
            end
            do_start(v);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(0, 3)) @(negedge CLK);
                act_in = v2;
                start  = 1'b1;
                @(negedge CLK);
                start  = 1'b0;
            end
            if ($urandom_range(0, 7) == 0) begin
                clr_pulse_mid_cycle();
            end else begin
                wait_done(400);
                repeat ($urandom_range(0, 2)) @(negedge CLK);
            end
        end

        @(negedge CLK);
        cmp_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
